// File: rtl/util_timestamp_axis_framer.sv
// util_timestamp_axis_framer
//   Takes the packed write stream of util_cpack2_timestamp (MAGIC header, timestamp,
//   then frame_words data words), buffers it in a first-word-fall-through FIFO and
//   emits an AXI4-Stream with tlast on the last data word of each frame. A frame is
//   admitted or dropped as a whole at its header, depending on the free FIFO space.
//   With frame_words == 0 every word passes through unparsed with tlast = 0.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   frame_words                data words per frame (0 = passthrough)
//   packed_fifo_wr_en/_sync/_data  input word strobe, record-start flag, word
//   packed_fifo_wr_overflow    stretched drop indication for the upstream CDC
//   m_axis_tvalid/_tready/_tdata/_tlast  AXI4-Stream master towards the DMA
//   frames_dropped             saturating count of frames rejected at the header
//   frame_error                one-cycle pulse: sync seen inside a frame body
module util_timestamp_axis_framer #(
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter logic [63:0] MAGIC       = 64'h504D5453454D4954,
  parameter int unsigned OVF_STRETCH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] frame_words,
  input  logic        packed_fifo_wr_en,
  input  logic        packed_fifo_wr_sync,
  input  logic [63:0] packed_fifo_wr_data,
  output logic        packed_fifo_wr_overflow,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic [31:0] frames_dropped,
  output logic        frame_error
);

  localparam int unsigned DW = 64;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(OVF_STRETCH + 1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_TS,
    ST_DATA,
    ST_SKIP
  } state_t;

  state_t        r_state;
  logic [15:0]   r_fw_l;
  logic [15:0]   r_cnt;
  logic [31:0]   r_dropped;
  logic          r_frame_error;

  logic [DW:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_tvalid;

  logic [SW-1:0] r_stretch;
  logic          r_ovf;

  logic          w_pop;
  logic          w_full;
  logic [CW-1:0] w_free;
  logic [16:0]   w_need;
  logic          w_hdr;
  logic          w_fits;
  logic          w_push;
  logic          w_push_last;
  logic          w_we;
  logic          w_drop_trig;
  logic          w_frame_drop;
  logic          w_frame_err;
  logic [CW-1:0] w_count_nxt;
  logic [SW-1:0] w_stretch_nxt;

  // Occupancy-based status, all taken from the start-of-cycle state.
  assign w_pop  = r_tvalid && m_axis_tready;
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_free = CW'(FIFO_DEPTH) - r_count;
  assign w_need = 17'(frame_words) + 17'd2;
  assign w_hdr  = packed_fifo_wr_sync && (packed_fifo_wr_data == MAGIC);
  assign w_fits = (17'(w_free) >= w_need);

  // Per-word decode: what the current input word does to the FIFO and the status outputs.
  always_comb begin
    w_push       = 1'b0;
    w_push_last  = 1'b0;
    w_drop_trig  = 1'b0;
    w_frame_drop = 1'b0;
    w_frame_err  = 1'b0;
    if (packed_fifo_wr_en) begin
      case (r_state)
        ST_HUNT: begin
          if (frame_words == 16'd0) begin
            // Passthrough: a pop in the same cycle frees the slot we need.
            if (!w_full || w_pop) w_push = 1'b1;
            else                  w_drop_trig = 1'b1;
          end else if (w_hdr) begin
            if (w_fits) begin
              w_push = 1'b1;
            end else begin
              w_frame_drop = 1'b1;
              w_drop_trig  = 1'b1;
            end
          end
        end
        ST_TS: w_push = 1'b1;
        ST_DATA: begin
          w_push      = 1'b1;
          w_push_last = (r_cnt == r_fw_l - 16'd1);
          w_frame_err = packed_fifo_wr_sync && (r_cnt != 16'd0);
        end
        default: ;
      endcase
    end
  end

  // Admission already reserved space for the frame; the guard only protects passthrough.
  assign w_we        = w_push && (!w_full || w_pop);
  assign w_count_nxt = r_count + CW'(w_we) - CW'(w_pop);

  // Frame parser state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_fw_l        <= 16'd0;
      r_cnt         <= 16'd0;
      r_dropped     <= 32'd0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= w_frame_err;
      if (w_frame_drop && (r_dropped != 32'hFFFF_FFFF)) r_dropped <= r_dropped + 32'd1;
      if (packed_fifo_wr_en) begin
        case (r_state)
          ST_HUNT: begin
            if ((frame_words != 16'd0) && w_hdr) begin
              r_fw_l  <= frame_words;
              r_cnt   <= 16'd0;
              r_state <= w_fits ? ST_TS : ST_SKIP;
            end
          end
          ST_TS: begin
            r_cnt   <= 16'd0;
            r_state <= ST_DATA;
          end
          ST_DATA: begin
            if (w_push_last) r_state <= ST_HUNT;
            else             r_cnt   <= r_cnt + 16'd1;
          end
          ST_SKIP: begin
            // Swallow the timestamp plus fw_l data words of the rejected frame.
            if (r_cnt == r_fw_l) r_state <= ST_HUNT;
            else                 r_cnt   <= r_cnt + 16'd1;
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; tvalid tracks the post-update occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      if (w_we)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= w_count_nxt;
      r_tvalid <= (w_count_nxt != '0);
    end
  end

  // FIFO storage of {tlast, data}; not reset, occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr] <= {w_push_last, packed_fifo_wr_data};
  end

  // Retriggerable overflow stretcher.
  always_comb begin
    w_stretch_nxt = r_stretch;
    if (w_drop_trig)             w_stretch_nxt = SW'(OVF_STRETCH);
    else if (r_stretch != '0)    w_stretch_nxt = r_stretch - SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stretch <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_stretch <= w_stretch_nxt;
      r_ovf     <= (w_stretch_nxt != '0);
    end
  end

  // Head of FIFO is shown only while valid so the bus reads zero when idle.
  assign m_axis_tvalid           = r_tvalid;
  assign m_axis_tdata            = r_tvalid ? r_mem[r_rd_ptr][DW-1:0] : '0;
  assign m_axis_tlast            = r_tvalid ? r_mem[r_rd_ptr][DW] : 1'b0;
  assign packed_fifo_wr_overflow = r_ovf;
  assign frames_dropped          = r_dropped;
  assign frame_error             = r_frame_error;

endmodule

// File: tb/tb_util_timestamp_axis_framer.sv
// Testbench for util_timestamp_axis_framer (FIFO_DEPTH = 8).
// Stimulus pushes expected {tlast, data} beats into a queue; a monitor pops and
// compares on every accepted AXI-Stream beat.
module tb_util_timestamp_axis_framer;

  localparam int unsigned DEPTH = 8;
  localparam logic [63:0] MAGIC = 64'h504D5453454D4954;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] frame_words;
  logic        packed_fifo_wr_en;
  logic        packed_fifo_wr_sync;
  logic [63:0] packed_fifo_wr_data;
  logic        packed_fifo_wr_overflow;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [31:0] frames_dropped;
  logic        frame_error;

  always #5 clk = ~clk;

  util_timestamp_axis_framer #(
    .FIFO_DEPTH (DEPTH),
    .MAGIC      (MAGIC),
    .OVF_STRETCH(8)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .frame_words            (frame_words),
    .packed_fifo_wr_en      (packed_fifo_wr_en),
    .packed_fifo_wr_sync    (packed_fifo_wr_sync),
    .packed_fifo_wr_data    (packed_fifo_wr_data),
    .packed_fifo_wr_overflow(packed_fifo_wr_overflow),
    .m_axis_tvalid          (m_axis_tvalid),
    .m_axis_tready          (m_axis_tready),
    .m_axis_tdata           (m_axis_tdata),
    .m_axis_tlast           (m_axis_tlast),
    .frames_dropped         (frames_dropped),
    .frame_error            (frame_error)
  );

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_exp;
  int beats = 0;
  int ovf_cycles = 0;
  int ferr_pulses = 0;

  // Monitor: samples on the falling edge, between driver updates.
  always @(negedge clk) begin
    if (!reset) begin
      if (packed_fifo_wr_overflow) ovf_cycles++;
      if (frame_error) ferr_pulses++;
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got tlast=%0b tdata=%h expected no beat",
                   m_axis_tlast, m_axis_tdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== mon_exp) begin
            errors++;
            $display("FAIL beat got tlast=%0b tdata=%h expected tlast=%0b tdata=%h",
                     m_axis_tlast, m_axis_tdata, mon_exp[64], mon_exp[63:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] d, input logic s);
    packed_fifo_wr_en   = 1'b1;
    packed_fifo_wr_data = d;
    packed_fifo_wr_sync = s;
    tick();
    packed_fifo_wr_en   = 1'b0;
    packed_fifo_wr_sync = 1'b0;
  endtask

  // Header, timestamp and n data words; sync_at marks a data word carrying sync (-1 none).
  task automatic send_frame(input logic [63:0] ts, input logic [63:0] base, input int n,
                            input int sync_at, input bit admitted);
    wr(MAGIC, 1'b1);
    if (admitted) exp_q.push_back({1'b0, MAGIC});
    wr(ts, 1'b0);
    if (admitted) exp_q.push_back({1'b0, ts});
    for (int i = 0; i < n; i++) begin
      wr(base + 64'(i), (i == sync_at));
      if (admitted) exp_q.push_back({(i == n - 1), base + 64'(i)});
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    int o0;
    int e0;
    reset               = 1'b1;
    frame_words         = 16'd4;
    packed_fifo_wr_en   = 1'b0;
    packed_fifo_wr_sync = 1'b0;
    packed_fifo_wr_data = 64'd0;
    m_axis_tready       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_overflow", 64'(packed_fifo_wr_overflow), 64'd0);
    chk("rst_dropped", 64'(frames_dropped), 64'd0);
    chk("rst_frame_error", 64'(frame_error), 64'd0);

    // 1: single frame straight through
    m_axis_tready = 1'b1;
    b0 = beats;
    send_frame(64'h1234, 64'hD000, 4, -1, 1'b1);
    wait_drain(50);
    chk("t1_beats", 64'(beats - b0), 64'd6);
    chk("t1_dropped", 64'(frames_dropped), 64'd0);

    // 2: stalled sink, second frame does not fit and is dropped whole
    m_axis_tready = 1'b0;
    o0 = ovf_cycles;
    send_frame(64'h2001, 64'hA000, 4, -1, 1'b1);
    send_frame(64'h2002, 64'hB000, 4, -1, 1'b0);
    repeat (12) tick();
    chk("t2_dropped", 64'(frames_dropped), 64'd1);
    chk("t2_ovf_cycles", 64'(ovf_cycles - o0), 64'd8);
    chk("t2_tvalid_held", 64'(m_axis_tvalid), 64'd1);
    b0 = beats;
    m_axis_tready = 1'b1;
    wait_drain(50);
    chk("t2_beats", 64'(beats - b0), 64'd6);

    // 3: garbage before the header is discarded
    b0 = beats;
    wr(MAGIC, 1'b0);
    wr(64'h1111, 1'b1);
    wr(64'h2222, 1'b0);
    send_frame(64'h3003, 64'hC000, 4, -1, 1'b1);
    wait_drain(50);
    chk("t3_beats", 64'(beats - b0), 64'd6);

    // 4: passthrough, 9 words into an 8-deep FIFO with the sink stalled
    m_axis_tready = 1'b0;
    frame_words   = 16'd0;
    o0 = ovf_cycles;
    for (int i = 1; i <= 9; i++) begin
      wr(64'(i), 1'b0);
      if (i <= 8) exp_q.push_back({1'b0, 64'(i)});
    end
    repeat (12) tick();
    chk("t4_ovf_cycles", 64'(ovf_cycles - o0), 64'd8);
    chk("t4_dropped", 64'(frames_dropped), 64'd1);
    b0 = beats;
    m_axis_tready = 1'b1;
    wait_drain(50);
    chk("t4_beats", 64'(beats - b0), 64'd8);
    frame_words = 16'd4;

    // 5: sync inside the frame body flags an error but the word is kept
    e0 = ferr_pulses;
    b0 = beats;
    send_frame(64'h5005, 64'hE000, 4, 2, 1'b1);
    wait_drain(50);
    repeat (3) tick();
    chk("t5_frame_error", 64'(ferr_pulses - e0), 64'd1);
    chk("t5_beats", 64'(beats - b0), 64'd6);

    // 6: reset after the timestamp word loses the torn frame
    m_axis_tready = 1'b0;
    wr(MAGIC, 1'b1);
    wr(64'h6006, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_tvalid_after_reset", 64'(m_axis_tvalid), 64'd0);
    chk("t6_dropped_after_reset", 64'(frames_dropped), 64'd0);
    m_axis_tready = 1'b1;
    b0 = beats;
    send_frame(64'h6007, 64'hF000, 4, -1, 1'b1);
    wait_drain(50);
    chk("t6_beats", 64'(beats - b0), 64'd6);

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
